// File: rtl/wfg_drive_spi_arb_pkg.sv
// Shared types and default sizes for the SPI drive arbiter.
// Optional watchdog is enabled by defining WFG_DRIVE_SPI_ARB_TIMEOUT_EN.
package wfg_drive_spi_arb_pkg;

  localparam int DEF_NUM_CH          = 4;
  localparam int DEF_AXIS_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [7:0] div;
    logic       cpol;
    logic       lsbfirst;
    logic [1:0] dff;
    logic       sspol;
  } spi_cfg_t;

endpackage

// File: rtl/wfg_drive_spi_arb_rr.sv
// Combinational round-robin picker: first request at or after ptr+1, wrapping.
module wfg_drive_spi_arb_rr
  import wfg_drive_spi_arb_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int OW     = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [OW-1:0]     ptr,
  output logic [OW-1:0]     grant,
  output logic              any_req
);

  // Scan from farthest to nearest so the nearest requester after ptr wins last.
  always_comb begin
    grant   = '0;
    any_req = |req;
    for (int k = NUM_CH; k >= 1; k--) begin
      grant = req[(int'(ptr) + k) % NUM_CH] ? OW'((int'(ptr) + k) % NUM_CH) : grant;
    end
  end

endmodule

// File: rtl/wfg_drive_spi_arb.sv
// Round-robin arbiter/sequencer sharing one SPI drive engine among NUM_CH streams.
// Define WFG_DRIVE_SPI_ARB_TIMEOUT_EN to add the transfer watchdog and err_timeout_o.
module wfg_drive_spi_arb
  import wfg_drive_spi_arb_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int AXIS_DATA_WIDTH = DEF_AXIS_DATA_WIDTH
`ifdef WFG_DRIVE_SPI_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_W     = DEF_TIMEOUT_W
`endif
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wfg_pat_sync_i,
  input  logic                              ctrl_en_q_i,
  input  logic [NUM_CH-1:0]                 chan_en_q_i,
  input  logic [NUM_CH-1:0]                 s_axis_tvalid_i,
  output logic [NUM_CH-1:0]                 s_axis_tready_o,
  input  logic [NUM_CH*AXIS_DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [NUM_CH*8-1:0]               cfg_div_q_i,
  input  logic [NUM_CH-1:0]                 cfg_cpol_q_i,
  input  logic [NUM_CH-1:0]                 cfg_lsbfirst_q_i,
  input  logic [NUM_CH-1:0]                 cfg_sspol_q_i,
  input  logic [NUM_CH*2-1:0]               cfg_dff_q_i,
  output logic                              m_sync_o,
  output logic                              m_axis_tvalid_o,
  input  logic                              m_axis_tready_i,
  output logic [AXIS_DATA_WIDTH-1:0]        m_axis_tdata_o,
  output logic [7:0]                        m_div_o,
  output logic                              m_cpol_o,
  output logic                              m_lsbfirst_o,
  output logic [1:0]                        m_dff_o,
  output logic                              m_sspol_o,
  input  logic                              spi_cs_ni,
  output logic [NUM_CH-1:0]                 spi_cs_no,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] owner_o,
  output logic                              busy_o
`ifdef WFG_DRIVE_SPI_ARB_TIMEOUT_EN
  , output logic                            err_timeout_o
`endif
);

  localparam int OW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  arb_state_t           state;
  logic [OW-1:0]        owner;
  logic [OW-1:0]        ptr;
  logic [OW-1:0]        grant;
  logic                 any_req;
  logic [NUM_CH-1:0]    req;
  logic                 owner_req;
  logic                 handshake;
  logic                 seen_active;
  logic                 cs_match;
  logic                 timeout_hit;
  logic                 cs_mask;
  logic [NUM_CH-1:0]    cs_active;
  spi_cfg_t             cfg_own;
  logic [AXIS_DATA_WIDTH-1:0] data_own;

  assign req       = s_axis_tvalid_i & chan_en_q_i & {NUM_CH{ctrl_en_q_i}};
  assign owner_req = req[owner];
  assign handshake = (state == ST_OFFER) && m_axis_tready_i && owner_req;
  assign cs_match  = (spi_cs_ni == cfg_sspol_q_i[owner]);

  wfg_drive_spi_arb_rr #(
    .NUM_CH (NUM_CH),
    .OW     (OW)
  ) u_rr (
    .req     (req),
    .ptr     (ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  // Owner's data and config reach the engine only while a grant is held.
  always_comb begin
    cfg_own  = '0;
    data_own = '0;
    if (state != ST_IDLE) begin
      cfg_own.div      = cfg_div_q_i[int'(owner)*8 +: 8];
      cfg_own.cpol     = cfg_cpol_q_i[owner];
      cfg_own.lsbfirst = cfg_lsbfirst_q_i[owner];
      cfg_own.dff      = cfg_dff_q_i[int'(owner)*2 +: 2];
      cfg_own.sspol    = cfg_sspol_q_i[owner];
      data_own         = s_axis_tdata_i[int'(owner)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    end else begin
      cfg_own  = '0;
      data_own = '0;
    end
  end

  // Sequencer: grant, offer one beat, then follow the engine's cs through one frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      owner       <= '0;
      ptr         <= '0;
      seen_active <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner <= grant;
            state <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (timeout_hit || !owner_req) begin
            state <= ST_IDLE;
          end else if (m_axis_tready_i) begin
            ptr         <= owner;
            seen_active <= 1'b0;
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (timeout_hit) begin
            state <= ST_IDLE;
          end else if (!seen_active && cs_match) begin
            seen_active <= 1'b1;
          end else if (seen_active && !cs_match) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef WFG_DRIVE_SPI_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 err_timeout;
  logic                 tmo_mask;

  assign timeout_hit   = (state != ST_IDLE) && (&tmo_cnt);
  assign cs_mask       = tmo_mask;
  assign err_timeout_o = err_timeout;

  // Watchdog restarts on each state entry; a timed-out owner's cs stays masked until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
      tmo_mask    <= 1'b0;
    end else begin
      if ((state == ST_IDLE) || handshake) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
      end
      if (!ctrl_en_q_i) begin
        err_timeout <= 1'b0;
      end else if (timeout_hit) begin
        err_timeout <= 1'b1;
      end
      if (timeout_hit) begin
        tmo_mask <= 1'b1;
      end else if ((state == ST_IDLE) && any_req) begin
        tmo_mask <= 1'b0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign cs_mask     = 1'b0;
`endif

  // Only the owner's line may go active; it mirrors the engine cs one cycle late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_active <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cs_active[i] <= (owner == OW'(i)) && cs_match && !cs_mask && !timeout_hit;
      end
    end
  end

  assign spi_cs_no = ~(cs_active ^ cfg_sspol_q_i);

  // Upstream ready is the handshake routed back to the owner only.
  always_comb begin
    s_axis_tready_o = '0;
    if (handshake) begin
      s_axis_tready_o[owner] = 1'b1;
    end else begin
      s_axis_tready_o = '0;
    end
  end

  assign m_axis_tvalid_o = (state == ST_OFFER);
  assign m_sync_o        = (state == ST_OFFER) && wfg_pat_sync_i;
  assign m_axis_tdata_o  = data_own;
  assign m_div_o         = cfg_own.div;
  assign m_cpol_o        = cfg_own.cpol;
  assign m_lsbfirst_o    = cfg_own.lsbfirst;
  assign m_dff_o         = cfg_own.dff;
  assign m_sspol_o       = cfg_own.sspol;
  assign owner_o         = owner;
  assign busy_o          = (state != ST_IDLE);

endmodule

// File: tb/tb_wfg_drive_spi_arb.sv
// Scoreboard bench for wfg_drive_spi_arb with a small SPI engine model.
// Timeout scenario runs when WFG_DRIVE_SPI_ARB_TIMEOUT_EN is defined.
module tb_wfg_drive_spi_arb;

  typedef struct {
    int          ch;
    logic [31:0] data;
    logic [7:0]  div;
    logic        cpol;
    logic        lsb;
    logic [1:0]  dff;
    logic        sspol;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sync;
  logic         ctrl_en;
  logic [3:0]   chan_en;
  logic [3:0]   valid;
  logic [3:0]   tready;
  logic [127:0] tdata;
  logic [31:0]  div_flat;
  logic [3:0]   cpol, lsb, sspol;
  logic [7:0]   dff_flat;
  logic         m_sync, m_tvalid, m_tready;
  logic [31:0]  m_tdata;
  logic [7:0]   m_div;
  logic         m_cpol, m_lsb, m_sspol;
  logic [1:0]   m_dff;
  logic         spi_cs_ni;
  logic [3:0]   spi_cs_no;
  logic [1:0]   owner;
  logic         busy;
  logic         err_timeout;
  logic         eng_dead;

  logic [31:0] cdata [4] = '{32'h1111_0000, 32'h2222_0001, 32'hA5A5_0001, 32'h3C3C_0003};
  logic [7:0]  cdiv  [4] = '{8'd2, 8'd5, 8'h10, 8'h33};
  logic        ccpol [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic        clsb  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [1:0]  cdff  [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic        csspol[4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  exp_t sb[$];
  exp_t me;

  always #5 clk = ~clk;

  assign m_tready = m_sync & m_tvalid;

  wfg_drive_spi_arb #(
    .NUM_CH          (4),
    .AXIS_DATA_WIDTH (32)
`ifdef WFG_DRIVE_SPI_ARB_TIMEOUT_EN
    , .TIMEOUT_W     (4)
`endif
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wfg_pat_sync_i   (sync),
    .ctrl_en_q_i      (ctrl_en),
    .chan_en_q_i      (chan_en),
    .s_axis_tvalid_i  (valid),
    .s_axis_tready_o  (tready),
    .s_axis_tdata_i   (tdata),
    .cfg_div_q_i      (div_flat),
    .cfg_cpol_q_i     (cpol),
    .cfg_lsbfirst_q_i (lsb),
    .cfg_sspol_q_i    (sspol),
    .cfg_dff_q_i      (dff_flat),
    .m_sync_o         (m_sync),
    .m_axis_tvalid_o  (m_tvalid),
    .m_axis_tready_i  (m_tready),
    .m_axis_tdata_o   (m_tdata),
    .m_div_o          (m_div),
    .m_cpol_o         (m_cpol),
    .m_lsbfirst_o     (m_lsb),
    .m_dff_o          (m_dff),
    .m_sspol_o        (m_sspol),
    .spi_cs_ni        (spi_cs_ni),
    .spi_cs_no        (spi_cs_no),
    .owner_o          (owner),
    .busy_o           (busy)
`ifdef WFG_DRIVE_SPI_ARB_TIMEOUT_EN
    , .err_timeout_o  (err_timeout)
`endif
  );

`ifndef WFG_DRIVE_SPI_ARB_TIMEOUT_EN
  assign err_timeout = 1'b0;
`endif

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int ch);
    exp_t e;
    e.ch = ch; e.data = cdata[ch]; e.div = cdiv[ch]; e.cpol = ccpol[ch];
    e.lsb = clsb[ch]; e.dff = cdff[ch]; e.sspol = csspol[ch];
    sb.push_back(e);
  endtask

  function automatic logic [3:0] cs_expect(input int ch, input logic act);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (act && i == ch) ? csspol[i] : ~csspol[i];
    return v;
  endfunction

  task automatic wait_grant();
    int n = 0;
    while (!m_tvalid && n < 50) begin @(negedge clk); n++; end
    chk("wait_grant", m_tvalid, 1'b1);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin @(negedge clk); n++; end
    chk("wait_idle", busy, 1'b0);
  endtask

  // Grant, sync, handshake; with finish=1 also check cs/config in BUSY and wait for idle.
  task automatic run_xfer(input int ch, input bit oneshot, input bit finish);
    int h0;
    wait_grant();
    chk("grant_owner", owner, ch);
    push_exp(ch);
    h0 = hs_cnt;
    @(posedge clk); #1 sync = 1'b1;
    @(posedge clk); #1 sync = 1'b0;
    if (oneshot) valid[ch] = 1'b0;
    if (finish) begin
      repeat (2) @(negedge clk);
      chk("one_handshake", hs_cnt, h0 + 1);
      chk("busy_in_xfer", busy, 1'b1);
      chk("busy_div", m_div, cdiv[ch]);
      chk("busy_sspol", m_sspol, csspol[ch]);
      chk("cs_track", spi_cs_no, cs_expect(ch, 1'b1));
      wait_idle(50);
    end
  endtask

  // Scoreboard monitor: each engine handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_handshake", 1'b1, 1'b0);
      end else begin
        me = sb.pop_front();
        chk("hs_owner", owner, me.ch);
        chk("hs_data", m_tdata, me.data);
        chk("hs_div", m_div, me.div);
        chk("hs_cpol", m_cpol, me.cpol);
        chk("hs_lsb", m_lsb, me.lsb);
        chk("hs_dff", m_dff, me.dff);
        chk("hs_sspol", m_sspol, me.sspol);
        chk("hs_tready", tready, 4'b0001 << me.ch);
      end
    end else if (rst_n && busy && !m_tvalid) begin
      chk("busy_tready_low", tready, 4'b0000);
    end
  end

  // Engine model: after a handshake, cs inactive one cycle, active three, then inactive.
  initial begin
    logic sp;
    spi_cs_ni = 1'b1;
    forever begin
      @(negedge clk);
      if (m_tvalid && m_tready && !eng_dead) begin
        sp = m_sspol;
        spi_cs_ni = ~sp;
        @(negedge clk);
        spi_cs_ni = sp;
        repeat (3) @(negedge clk);
        spi_cs_ni = ~sp;
      end else begin
        spi_cs_ni = ~m_sspol;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int rr_order[6] = '{0, 1, 3, 0, 1, 3};
    int h0;
    rst_n = 1'b0; sync = 1'b0; ctrl_en = 1'b1; chan_en = 4'hF; valid = 4'h0; eng_dead = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tdata[i*32 +: 32] = cdata[i]; div_flat[i*8 +: 8] = cdiv[i];
      cpol[i] = ccpol[i]; lsb[i] = clsb[i]; dff_flat[i*2 +: 2] = cdff[i]; sspol[i] = csspol[i];
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 2'd0);
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_tdata", m_tdata, 32'h0);
    chk("rst_div", m_div, 8'h0);
    chk("rst_tready", tready, 4'h0);
    chk("rst_cs", spi_cs_no, 4'b1101);
    chk("rst_err", err_timeout, 1'b0);
    rst_n = 1'b1;

    // Single channel 2, then channel 3 so the round robin starts from ch0.
    valid[2] = 1'b1; run_xfer(2, 1'b1, 1'b1);
    valid[3] = 1'b1; run_xfer(3, 1'b1, 1'b1);

    valid = 4'b1011;
    for (int k = 0; k < 6; k++) run_xfer(rr_order[k], 1'b0, 1'b1);
    valid = 4'b0000;

    // Per-channel config: ch1 is active-high cs.
    valid[1] = 1'b1; run_xfer(1, 1'b1, 1'b1);
    valid[0] = 1'b1; run_xfer(0, 1'b1, 1'b1);

    // Withdraw in OFFER: pointer stays at 0, so ch1 beats ch2 afterwards.
    valid[1] = 1'b1;
    wait_grant();
    chk("wd_owner", owner, 2'd1);
    h0 = hs_cnt;
    @(negedge clk);
    chk("wd_no_ready", tready, 4'h0);
    @(posedge clk); #1 valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("wd_idle", busy, 1'b0);
    chk("wd_no_hs", hs_cnt, h0);
    valid = 4'b0110;
    run_xfer(1, 1'b1, 1'b1);
    run_xfer(2, 1'b1, 1'b1);

    // Reset during BUSY.
    valid[2] = 1'b1; run_xfer(2, 1'b1, 1'b0);
    @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_owner", owner, 2'd0);
    chk("mid_rst_div", m_div, 8'h0);
    chk("mid_rst_cs", spi_cs_no, 4'b1101);
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    valid = 4'b0011;
    run_xfer(1, 1'b1, 1'b1);
    run_xfer(0, 1'b1, 1'b1);

    // Global disable during BUSY: transfer finishes, no regrant until re-enabled.
    valid = 4'b1000; run_xfer(3, 1'b0, 1'b0);
    ctrl_en = 1'b0;
    wait_idle(50);
    repeat (3) begin
      @(negedge clk);
      chk("dis_no_grant", busy, 1'b0);
    end
    ctrl_en = 1'b1;
    run_xfer(3, 1'b1, 1'b1);

`ifdef WFG_DRIVE_SPI_ARB_TIMEOUT_EN
    eng_dead = 1'b1;
    valid[3] = 1'b1; run_xfer(3, 1'b1, 1'b0);
    @(negedge clk);
    chk("tmo_still_busy", busy, 1'b1);
    wait_idle(40);
    chk("tmo_err_set", err_timeout, 1'b1);
    chk("tmo_cs_inactive", spi_cs_no, 4'b1101);
    repeat (2) @(negedge clk);
    chk("tmo_err_sticky", err_timeout, 1'b1);
    ctrl_en = 1'b0;
    @(negedge clk);
    chk("tmo_err_clear", err_timeout, 1'b0);
    ctrl_en = 1'b1; eng_dead = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
